// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_CPU      = 2'd0,
    ARB_HOST_ACC = 2'd1,
    ARB_HOST_RSP = 2'd2
  } arb_state_e;

  localparam logic [3:0]  WSTRB_FULL   = 4'b1111;
  localparam int unsigned STARVE_CNT_W = 8;

endpackage

// File: rtl/dmem_port_mux.sv
// RAM-side request mux: the CPU MEM stage drives the RAM unless the host owns it.
module dmem_port_mux
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              host_sel,
  input  logic              cpu_req_M,
  input  logic              cpu_we_M,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [31:0]       cpu_wdata_M,
  input  logic [3:0]        cpu_wstrb_M,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [31:0]       host_wdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata
);

  // Select the RAM command source; host writes are always full-word.
  always_comb begin
    mem_en    = cpu_req_M;
    mem_we    = cpu_we_M ? cpu_wstrb_M : '0;
    mem_addr  = cpu_waddr;
    mem_wdata = cpu_wdata_M;
    if (host_sel) begin
      mem_en    = 1'b1;
      mem_we    = host_we ? WSTRB_FULL : '0;
      mem_addr  = host_waddr;
      mem_wdata = host_wdata;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-RAM port arbiter: CPU MEM stage by default, host accesses slotted into
// CPU-idle cycles or forced in after a starvation limit.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned HOST_STARVE_LIM = 8
) (
  input  logic              DMEM_ARB_clk,
  input  logic              DMEM_ARB_rst,
  input  logic              cpu_req_M,
  input  logic              cpu_we_M,
  input  logic [31:0]       cpu_addr_M,
  input  logic [31:0]       cpu_wdata_M,
  input  logic [3:0]        cpu_wstrb_M,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [31:0]       host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_ack,
  output logic [31:0]       host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(HOST_STARVE_LIM);
  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = '1;

  arb_state_e              state;
  arb_state_e              state_nxt;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    cpu_rd_q;
  logic                    host_rd_pend;
  logic                    host_sel;
  logic                    host_win;
  logic [ADDR_W-1:0]       cpu_waddr;
  logic [ADDR_W-1:0]       host_waddr;
  logic                    addr_unused;

  // Word addresses alias above ADDR_W+1; the byte offset belongs to MEM_WB alignment.
  assign cpu_waddr   = cpu_addr_M[ADDR_W+1:2];
  assign host_waddr  = host_addr[ADDR_W+1:2];
  assign addr_unused = ^{cpu_addr_M[31:ADDR_W+2], cpu_addr_M[1:0],
                         host_addr[31:ADDR_W+2], host_addr[1:0]};

  assign host_win = host_req && (!cpu_req_M || (starve_cnt >= STARVE_LIM));

  // State register.
  always_ff @(posedge DMEM_ARB_clk) begin
    if (DMEM_ARB_rst) state <= ARB_CPU;
    else              state <= state_nxt;
  end

  // Next state: host slot is always ACC then RSP, so it never wins twice in a row.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_CPU:      if (host_win) state_nxt = ARB_HOST_ACC;
      ARB_HOST_ACC: state_nxt = ARB_HOST_RSP;
      ARB_HOST_RSP: state_nxt = ARB_CPU;
      default:      state_nxt = ARB_CPU;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    host_sel  = (state == ARB_HOST_ACC);
    host_ack  = host_sel;
    cpu_stall = host_sel && cpu_req_M;
  end

  // Count consecutive cycles the host lost to a busy CPU.
  always_ff @(posedge DMEM_ARB_clk) begin
    if (DMEM_ARB_rst || !host_req) begin
      starve_cnt <= '0;
    end else if (state == ARB_CPU) begin
      if (host_win)                      starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Read-return bookkeeping for both requesters; host_we is latched in ACC
  // because the host may change it once it has seen host_ack.
  always_ff @(posedge DMEM_ARB_clk) begin
    if (DMEM_ARB_rst) begin
      cpu_rd_q     <= 1'b0;
      host_rd_pend <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
    end else begin
      cpu_rd_q     <= !host_sel && cpu_req_M && !cpu_we_M;
      host_rd_pend <= host_sel && !host_we;
      host_rvalid  <= (state == ARB_HOST_RSP) && host_rd_pend;
      if ((state == ARB_HOST_RSP) && host_rd_pend) host_rdata <= mem_rdata;
    end
  end

  assign cpu_rdata = cpu_rd_q ? mem_rdata : '0;

  dmem_port_mux #(
    .ADDR_W(ADDR_W)
  ) u_port_mux (
    .host_sel    (host_sel),
    .cpu_req_M   (cpu_req_M),
    .cpu_we_M    (cpu_we_M),
    .cpu_waddr   (cpu_waddr),
    .cpu_wdata_M (cpu_wdata_M),
    .cpu_wstrb_M (cpu_wstrb_M),
    .host_we     (host_we),
    .host_waddr  (host_waddr),
    .host_wdata  (host_wdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios then random traffic, all
// checked every cycle against a slot/queue-level reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LIM    = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_M, cpu_we_M;
  logic [31:0]       cpu_addr_M, cpu_wdata_M;
  logic [3:0]        cpu_wstrb_M;
  logic              cpu_stall;
  logic [31:0]       cpu_rdata;
  logic              host_req, host_we;
  logic [31:0]       host_addr, host_wdata;
  logic              host_ack;
  logic [31:0]       host_rdata;
  logic              host_rvalid;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  // RAM seen by the DUT and the model's own view of its contents
  logic [31:0] ram  [DEPTH];
  logic [31:0] gold [DEPTH];
  bit          ram_init_done = 1'b0;

  // Reference model: host slot phase (0 none, 1 issuing, 2 response cycle)
  int          phase;
  int          denied;
  logic [31:0] exp_cpu_rdata, exp_hrdata, host_read_val;
  bit          exp_rvalid, rd_pend, last_ack;

  always #5 clk = ~clk;

  dmem_port_arbiter #(
    .ADDR_W          (ADDR_W),
    .HOST_STARVE_LIM (LIM)
  ) dut (
    .DMEM_ARB_clk (clk),
    .DMEM_ARB_rst (rst),
    .cpu_req_M    (cpu_req_M),
    .cpu_we_M     (cpu_we_M),
    .cpu_addr_M   (cpu_addr_M),
    .cpu_wdata_M  (cpu_wdata_M),
    .cpu_wstrb_M  (cpu_wstrb_M),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_rvalid  (host_rvalid),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Single-port synchronous RAM, read-first
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] = gold[i];
      end
      ram_init_done = 1'b1;
    end
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic logic [31:0] raddr();
    return ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 31)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  // One clock cycle: drive, check every output against the model, advance the model
  task automatic step(input logic r, input logic creq, input logic cwe,
                      input logic [31:0] caddr, input logic [31:0] cwdata,
                      input logic [3:0] cstrb, input logic hreq, input logic hwe,
                      input logic [31:0] haddr, input logic [31:0] hwdata);
    bit          host_now;
    bit          e_en;
    logic [3:0]  e_we;
    int unsigned e_a;
    logic [31:0] e_wd, nxt_cpu;
    @(negedge clk);
    rst = r; cpu_req_M = creq; cpu_we_M = cwe; cpu_addr_M = caddr;
    cpu_wdata_M = cwdata; cpu_wstrb_M = cstrb;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwdata;
    #1;
    host_now = (phase == 1);
    if (host_now) begin
      e_en = 1'b1; e_we = hwe ? 4'hF : 4'h0; e_a = widx(haddr); e_wd = hwdata;
    end else begin
      e_en = creq; e_we = cwe ? cstrb : 4'h0; e_a = widx(caddr); e_wd = cwdata;
    end
    chk("mem_en",      32'(mem_en),      32'(e_en));
    chk("mem_we",      32'(mem_we),      32'(e_we));
    chk("mem_addr",    32'(mem_addr),    32'(e_a));
    chk("mem_wdata",   mem_wdata,        e_wd);
    chk("cpu_stall",   32'(cpu_stall),   32'(host_now && creq));
    chk("host_ack",    32'(host_ack),    32'(host_now));
    chk("cpu_rdata",   cpu_rdata,        exp_cpu_rdata);
    chk("host_rvalid", 32'(host_rvalid), 32'(exp_rvalid));
    chk("host_rdata",  host_rdata,       exp_hrdata);

    last_ack = host_now;
    nxt_cpu  = (!host_now && creq && !cwe) ? gold[e_a] : 32'd0;
    if (host_now && !hwe) host_read_val = gold[e_a];
    if (e_en) begin
      for (int b = 0; b < 4; b++) begin
        if (e_we[b]) gold[e_a][8*b +: 8] = e_wd[8*b +: 8];
      end
    end
    if (r) begin
      phase = 0; denied = 0; exp_cpu_rdata = '0; exp_rvalid = 1'b0;
      exp_hrdata = '0; rd_pend = 1'b0;
    end else begin
      exp_rvalid = (phase == 2) && rd_pend;
      if (exp_rvalid) exp_hrdata = host_read_val;
      rd_pend       = host_now && !hwe;
      exp_cpu_rdata = nxt_cpu;
      if (phase == 1)      phase = 2;
      else if (phase == 2) phase = 0;
      else if (hreq && (!creq || denied >= LIM)) begin
        phase = 1; denied = 0;
      end else if (hreq) begin
        if (denied < 255) denied++;
      end else begin
        denied = 0;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // Hold one host request (with a fixed CPU pattern) until it is acknowledged
  task automatic host_xfer(input logic hwe, input logic [31:0] haddr, input logic [31:0] hwdata,
                           input logic creq, input logic cwe, input logic [31:0] caddr,
                           output int n);
    n = 0;
    last_ack = 1'b0;
    while (!last_ack && n < 300) begin
      step(1'b0, creq, cwe, caddr, 32'h1234_5678, 4'hF, 1'b1, hwe, haddr, hwdata);
      n++;
    end
    chk("host_ack_seen", 32'(host_ack), 32'd1);
  endtask

  initial begin
    int          n;
    bit          hb;
    logic        hwe_r, creq_r;
    logic [31:0] ha_r, hd_r;

    rst = 1'b1; cpu_req_M = 1'b0; cpu_we_M = 1'b0; cpu_addr_M = '0; cpu_wdata_M = '0;
    cpu_wstrb_M = '0; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    for (int i = 0; i < DEPTH; i++) gold[i] = $urandom;
    phase = 0; denied = 0; exp_cpu_rdata = '0; exp_hrdata = '0; host_read_val = '0;
    exp_rvalid = 1'b0; rd_pend = 1'b0; last_ack = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0);

    // Host write with the CPU idle
    host_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, n);
    chk("wr_ack_latency", 32'(n), 32'd2);
    idle();

    // Host read back, rvalid two cycles after ack
    host_xfer(1'b0, 32'h40, '0, 1'b0, 1'b0, '0, n);
    idle();
    idle();
    chk("rd_rvalid", 32'(host_rvalid), 32'd1);
    chk("rd_rdata",  host_rdata,       32'hDEAD_BEEF);

    // CPU loads every cycle: host forced in after the starvation limit
    host_xfer(1'b0, 32'h80, '0, 1'b1, 1'b0, 32'h40, n);
    chk("starve_ack_cycle", 32'(n), 32'(LIM + 2));
    chk("starve_stall", 32'(cpu_stall), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h40, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("starve_rdata_blank", cpu_rdata, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h40, '0, '0, 1'b0, 1'b0, '0, '0);
    chk("starve_retry_rdata", cpu_rdata, 32'hDEAD_BEEF);
    idle();

    // CPU byte store races a new host read; CPU wins first
    step(1'b0, 1'b1, 1'b1, 32'h43, 32'hAB00_0000, 4'b1000, 1'b1, 1'b0, 32'h40, '0);
    host_xfer(1'b0, 32'h40, '0, 1'b0, 1'b0, '0, n);
    chk("sb_host_wait", 32'(n), 32'd2);
    idle();
    idle();
    chk("sb_merged_word", host_rdata, 32'hABAD_BEEF);

    // Reset during the issue cycle of a host read
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h44, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'h44, '0);
    idle();
    chk("rst_acc_no_rvalid0", 32'(host_rvalid), 32'd0);
    idle();
    chk("rst_acc_no_rvalid1", 32'(host_rvalid), 32'd0);

    // Back-to-back host requests with the CPU idle
    for (int k = 0; k < 6; k++) begin
      host_xfer(logic'(k % 2 == 0), 32'h100 + 32'(4 * k), $urandom, 1'b0, 1'b0, '0, n);
      if (k > 0) chk("b2b_ack_gap", 32'(n), 32'd3);
    end
    repeat (3) idle();

    // Random traffic with legal host handshakes and occasional reset
    hb = 1'b0; hwe_r = 1'b0; ha_r = '0; hd_r = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!hb && $urandom_range(0, 2) == 0) begin
        hb = 1'b1; hwe_r = logic'($urandom_range(0, 1)); ha_r = raddr(); hd_r = $urandom;
      end
      creq_r = (k < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) != 0);
      step(logic'($urandom_range(0, 299) == 0), creq_r, logic'($urandom_range(0, 1)),
           raddr(), $urandom, 4'($urandom_range(0, 15)), hb, hwe_r, ha_r, hd_r);
      if (last_ack) hb = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
